// File: rtl/bounce_gen.sv
// Switch-bounce emulator: drives an odd-length burst of toggles ending at the requested
// level, then holds it for a settle window and pulses done. `BOUNCE_GEN_FIXED_EN` fixes every segment at 2^SEG_BITS cycles.
module bounce_gen #(
   parameter int unsigned BOUNCE_COUNT  = 3,
   parameter int unsigned SEG_BITS      = 4,
   parameter int unsigned SETTLE_CYCLES = 32,
   parameter logic [15:0] LFSR_SEED     = 16'hACE1,
   parameter logic        INIT_LEVEL    = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic req_valid,
   input  logic req_level,
   output logic req_ready,
   output logic noisy_out,
   output logic busy,
   output logic done
);
   localparam int unsigned SW = $clog2(SETTLE_CYCLES + 1);
   localparam logic [8:0]          TOG_LD    = 9'(2 * BOUNCE_COUNT);
   localparam logic [8:0]          TOG_ONE   = 9'd1;
   localparam logic [SEG_BITS:0]   SEG_ONE   = (SEG_BITS + 1)'(1);
   localparam logic [SW-1:0]       SETTLE_LD = SW'(SETTLE_CYCLES);
   localparam logic [SW-1:0]       SET_ONE   = SW'(1);

   typedef enum logic [1:0] {S_IDLE, S_BOUNCE, S_SETTLE} state_t;

   state_t            state_q, state_d;
   logic              noisy_q, noisy_d;
   logic              done_q, done_d;
   logic [8:0]        tog_q, tog_d;
   logic [SEG_BITS:0] seg_q, seg_d;
   logic [SW-1:0]     set_q, set_d;
   logic [SEG_BITS:0] seg_len;

`ifdef BOUNCE_GEN_FIXED_EN
   assign seg_len = {1'b1, {SEG_BITS{1'b0}}};
`else
   logic [15:0] lfsr_q;
   assign seg_len = {1'b0, lfsr_q[SEG_BITS-1:0]} + SEG_ONE;

   // Advance only when a segment length is consumed: on entry to BOUNCE or on a reload.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         lfsr_q <= LFSR_SEED;
      else if (state_d == S_BOUNCE && (state_q == S_IDLE || seg_q == SEG_ONE))
         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
   end
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         noisy_q <= INIT_LEVEL;
         done_q  <= 1'b0;
         tog_q   <= '0;
         seg_q   <= '0;
         set_q   <= '0;
      end else begin
         state_q <= state_d;
         noisy_q <= noisy_d;
         done_q  <= done_d;
         tog_q   <= tog_d;
         seg_q   <= seg_d;
         set_q   <= set_d;
      end
   end

   always_comb begin
      state_d = state_q;
      noisy_d = noisy_q;
      done_d  = 1'b0;
      tog_d   = tog_q;
      seg_d   = seg_q;
      set_d   = set_q;
      case (state_q)
         S_IDLE: begin
            if (req_valid) begin
               if (req_level == noisy_q) begin
                  done_d = 1'b1;
               end else begin
                  noisy_d = ~noisy_q;
                  tog_d   = TOG_LD;
                  if (TOG_LD == 9'd0) begin
                     state_d = S_SETTLE;
                     set_d   = SETTLE_LD;
                  end else begin
                     state_d = S_BOUNCE;
                     seg_d   = seg_len;
                  end
               end
            end
         end
         S_BOUNCE: begin
            // seg_q == 1 marks the edge where noisy has been held exactly seg_len cycles
            if (seg_q == SEG_ONE) begin
               noisy_d = ~noisy_q;
               tog_d   = tog_q - TOG_ONE;
               if (tog_q == TOG_ONE) begin
                  state_d = S_SETTLE;
                  set_d   = SETTLE_LD;
               end else begin
                  seg_d = seg_len;
               end
            end else begin
               seg_d = seg_q - SEG_ONE;
            end
         end
         S_SETTLE: begin
            if (set_q == SET_ONE) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
               set_d   = '0;
            end else begin
               set_d = set_q - SET_ONE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      busy      = (state_q != S_IDLE);
      req_ready = ~busy;
      noisy_out = noisy_q;
      done      = done_q;
   end
endmodule

// File: tb/tb_bounce_gen.sv
// Scoreboard bench for bounce_gen: each accepted request pushes its predicted toggle
// and done events; a negedge monitor pops and compares them as the DUT produces them.
module tb_bounce_gen;
   localparam int BC = 3;
   localparam int SB = 4;
   localparam int SC = 32;

   typedef struct packed {
      int   cyc;
      logic dn;
      logic lvl;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic req_valid = 1'b0, req_level = 1'b0;
   logic req_ready, noisy_out, busy, done;
   logic v0 = 1'b0, l0 = 1'b0;
   logic rdy0, n0, b0, d0;

   int   cyc = 0;
   int   errs = 0, nchk = 0;
   int   n_done = 0, exp_done = 0;
   int   busy_lo = 0, busy_hi = 0;
   ev_t  q[$];
   logic [15:0] m_lfsr = 16'hACE1;
   logic m_lvl = 1'b0;
   logic prev = 1'b0;

   bounce_gen #(.BOUNCE_COUNT(BC), .SEG_BITS(SB), .SETTLE_CYCLES(SC),
                .LFSR_SEED(16'hACE1), .INIT_LEVEL(1'b0)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_level(req_level),
      .req_ready(req_ready), .noisy_out(noisy_out), .busy(busy), .done(done));

   bounce_gen #(.BOUNCE_COUNT(0), .SEG_BITS(SB), .SETTLE_CYCLES(1),
                .LFSR_SEED(16'hACE1), .INIT_LEVEL(1'b0)) dut0 (
      .clk(clk), .rst(rst), .req_valid(v0), .req_level(l0),
      .req_ready(rdy0), .noisy_out(n0), .busy(b0), .done(d0));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0d expected %0d (cyc %0d)", tag, act, exp, cyc);
      end
   endtask

   // Predicted events for a request accepted at edge a (observed at the negedge after a).
   task automatic model_accept(input int a, input logic lvl);
      int   t;
      logic l;
      if (lvl == m_lvl) begin
         q.push_back('{a, 1'b1, lvl});
      end else begin
         t = a;
         l = ~m_lvl;
         q.push_back('{t, 1'b0, l});
         for (int k = 0; k < 2 * BC; k++) begin
`ifdef BOUNCE_GEN_FIXED_EN
            t += (1 << SB);
`else
            t += int'(m_lfsr[SB-1:0]) + 1;
            m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
`endif
            l = ~l;
            q.push_back('{t, 1'b0, l});
         end
         q.push_back('{t + SC, 1'b1, l});
         busy_lo = a;
         busy_hi = t + SC;
         m_lvl   = lvl;
      end
      exp_done++;
   endtask

   task automatic send(input logic lvl);
      int n = 0;
      @(negedge clk);
      req_valid = 1'b1;
      req_level = lvl;
      while (req_ready !== 1'b1 && n < 1000) begin
         @(negedge clk);
         n++;
      end
      if (req_ready !== 1'b1) begin
         check("hs_timeout", n, 0);
         req_valid = 1'b0;
         return;
      end
      model_accept(cyc + 1, lvl);
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   initial begin
      ev_t  e;
      logic bexp;
      forever begin
         @(negedge clk);
         if (!rst) begin
            while (q.size() > 0 && q[0].cyc < cyc) begin
               check("missed_ev", cyc, q[0].cyc);
               void'(q.pop_front());
            end
            if (noisy_out !== prev) begin
               if (q.size() == 0) check("unexp_tog", 1, 0);
               else begin
                  e = q.pop_front();
                  check("tog_kind", int'(e.dn), 0);
                  check("tog_cyc", cyc, e.cyc);
                  check("tog_lvl", int'(noisy_out), int'(e.lvl));
               end
            end
            if (done === 1'b1) begin
               n_done++;
               if (q.size() == 0) check("unexp_done", 1, 0);
               else begin
                  e = q.pop_front();
                  check("done_kind", int'(e.dn), 1);
                  check("done_cyc", cyc, e.cyc);
                  check("done_lvl", int'(noisy_out), int'(e.lvl));
               end
            end
            bexp = (cyc >= busy_lo && cyc < busy_hi);
            check("busy", int'(busy), int'(bexp));
            check("ready", int'(req_ready), int'(!bexp));
         end
         prev = noisy_out;
      end
   end

   initial begin
      int n;
      repeat (3) @(negedge clk);
      check("rst_noisy", int'(noisy_out), 0);
      check("rst_ready", int'(req_ready), 1);
      check("rst_busy", int'(busy), 0);
      check("rst_done", int'(done), 0);
      rst = 1'b0;

      // Mid-burst reset: the aborted request must produce no done.
      send(1'b1);
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("abort_noisy", int'(noisy_out), 0);
      check("abort_ready", int'(req_ready), 1);
      check("abort_busy", int'(busy), 0);
      check("abort_done", int'(done), 0);
      foreach (q[i]) if (q[i].dn) exp_done--;
      q.delete();
      m_lfsr = 16'hACE1;
      m_lvl = 1'b0;
      busy_lo = 0;
      busy_hi = 0;
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Replay from the reset seed, then a same-level request (done only, never busy).
      send(1'b1);
      send(1'b1);

      // Alternating requests raised while busy; each is taken on the done cycle.
      for (int i = 0; i < 100; i++) send(i[0] ? 1'b1 : 1'b0);

      // Zero-bounce instance: single toggle at accept, done one cycle later.
      @(negedge clk);
      v0 = 1'b1;
      l0 = 1'b1;
      @(negedge clk);
      v0 = 1'b0;
      check("z_tog", int'(n0), 1);
      check("z_busy", int'(b0), 1);
      check("z_done0", int'(d0), 0);
      @(negedge clk);
      check("z_level", int'(n0), 1);
      check("z_done1", int'(d0), 1);
      check("z_idle", int'(b0), 0);
      check("z_ready", int'(rdy0), 1);
      @(negedge clk);
      check("z_done2", int'(d0), 0);

      n = 0;
      while (q.size() > 0 && n < 2000) begin
         @(negedge clk);
         n++;
      end
      repeat (4) @(negedge clk);
      check("drain", q.size(), 0);
      check("done_count", n_done, exp_done);
      check("final_level", int'(noisy_out), int'(m_lvl));
      $display("Result: errors=%0d of %0d checks", errs, nchk);
      $finish;
   end
endmodule

// File: doc/bounce_gen.md
Name: bounce_gen

Overview:
- Switch-bounce emulator: the source end of the debouncer interface, driving a debouncer's noisy input.
- Accepts a requested clean level through a valid/ready handshake.
- Drives noisy_out through a burst of pseudo-random-width toggles ending at the requested level, holds it stable for a settle window, then pulses done.
- Used in FPGA self-test and in benches to stimulate the debouncer top.

Parameters:
- BOUNCE_COUNT, 3: bounce pairs per transition; total toggles = 2*BOUNCE_COUNT+1. Range 0..255.
- SEG_BITS, 4: segment length field width; segment length = lfsr[SEG_BITS-1:0]+1, range 1..2^SEG_BITS cycles. Range 1..15.
- SETTLE_CYCLES, 32: stable cycles after the last toggle before done. Must be >=1.
- LFSR_SEED, 16'hACE1: LFSR reset value. Must be nonzero.
- INIT_LEVEL, 1'b0: noisy_out value after reset.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- req_valid  input  1  level-change request valid
- req_level  input  1  requested final level
- req_ready  output  1  high in IDLE only
- noisy_out  output  1  emulated bouncing switch line (registered)
- busy  output  1  high in BOUNCE or SETTLE
- done  output  1  one-cycle pulse when a request completes

Behaviour:
- Reset values (async assert, sync release): state IDLE, noisy_out=INIT_LEVEL, req_ready=1, busy=0, done=0, lfsr=LFSR_SEED, counters 0.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts left with feedback into bit 0. Advances exactly once per segment load, never otherwise.
- IDLE: noisy_out holds. A request is accepted at a rising edge with req_valid && req_ready.
- Accept with req_level != noisy_out:
  - Same edge: noisy_out toggles (toggle 1); toggle counter = 2*BOUNCE_COUNT.
  - If counter is 0 after the toggle, go to SETTLE; otherwise go to BOUNCE, load seg_cnt from the current lfsr, advance lfsr.
- BOUNCE:
  - seg_cnt decrements each cycle. When it reaches the end of the segment (noisy_out held exactly seg_len cycles), toggle noisy_out and decrement the toggle counter.
  - If more toggles remain, reload seg_cnt and advance lfsr; otherwise enter SETTLE.
  - The final level always equals req_level (odd toggle count).
- SETTLE:
  - noisy_out constant for SETTLE_CYCLES cycles counted from the last-toggle edge.
  - At edge last_toggle+SETTLE_CYCLES: state IDLE, done=1 for one cycle, req_ready=1.
- Accept with req_level == noisy_out: no toggles, no settle. done=1 in the next cycle; state stays IDLE; lfsr unchanged.
- req_valid while busy: ignored, not queued (req_ready=0). The requester must hold req_valid until the handshake.
- done may coincide with a new acceptance in the same cycle; the new request proceeds normally.
- Counter widths: toggle counter 9 bits; seg_cnt SEG_BITS+1 bits; settle counter clog2(SETTLE_CYCLES+1) bits. No wrap-around is permitted.
- Reset mid-operation returns all state to reset values immediately. No done pulse is produced for the aborted request.
- busy = (state != IDLE); req_ready = !busy.

Optional Feature:
- BOUNCE_GEN_FIXED_EN defined: the LFSR is not instantiated and every segment length is exactly 2^SEG_BITS cycles, giving deterministic timing for directed tests.
- Undefined: pseudo-random segment lengths as above.
- The port list is identical in both builds.

Test Plan:
- Fixed mode (BOUNCE_GEN_FIXED_EN, SEG_BITS=2, BOUNCE_COUNT=2, SETTLE_CYCLES=8, INIT_LEVEL=0), request level 1 at edge 0 -> noisy_out 1,0,1,0,1 changing at edges 0,4,8,12,16; stable 1 thereafter; done high only in the cycle after edge 24; busy high from edge 0 to edge 24.
- Same config, request level 0 while noisy_out=0 -> zero toggles, done in the next cycle, busy never asserted.
- BOUNCE_COUNT=0, SETTLE_CYCLES=1, request 1 from 0 -> single toggle at the accept edge, done one cycle later.
- Random mode, defaults, 100 alternating requests -> 7 toggles each; every segment 1..16 cycles; final level == req_level; done count == 100; sequence reproducible for the same LFSR_SEED.
- req_valid held high during BOUNCE with the opposite level -> ignored until req_ready; accepted on the done cycle; that transition starts immediately.
- Assert rst at edge 6 of the first scenario -> noisy_out=0, req_ready=1, no done; a new request after release behaves exactly like the first scenario.
